// File: rtl/ofm_addr_pkg.sv
// ofm_addr_pkg: shared definitions for the OFM write-address sequencer.
//   state_t    : sequencer FSM encoding (IDLE, EMIT, UPDATE)
//   calc_plane : pixels per output channel plane (OFM_H * OFM_W)
//   lane_width : bit width of a lane index, never narrower than 1 bit
// Optional feature macro used by the sequencer: OFM_ADDR_STALL_EN.
package ofm_addr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EMIT   = 2'd1,
      ST_UPDATE = 2'd2
   } state_t;

   function automatic int unsigned calc_plane(input int unsigned h, input int unsigned w);
      return h * w;
   endfunction

   function automatic int unsigned lane_width(input int unsigned lanes);
      if (lanes > 32'd1) begin
         return $clog2(lanes);
      end else begin
         return 32'd1;
      end
   endfunction

endpackage

// File: rtl/ofm_tile_cursor.sv
// ofm_tile_cursor: pixel / channel-group cursor of the OFM address sequencer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous return to pixel 0, channel group 0
//   advance     : step the cursor to the next tile (one-cycle pulse)
//   tile_base   : ch_base*PLANE + pix_base, maintained incrementally
//   last_lane   : index of the last active lane of the current tile (n-1)
//   last_tile   : current tile is the final tile of the layer
module ofm_tile_cursor
   import ofm_addr_pkg::*;
#(
   parameter int unsigned SYSTOLIC_SIZE = 16,
   parameter int unsigned PLANE         = 1024,
   parameter int unsigned NUM_CHANNEL   = 16,
   parameter int unsigned ADDR_WIDTH    = 14,
   parameter int unsigned LANE_W        = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  advance,
   output logic [ADDR_WIDTH-1:0] tile_base,
   output logic [LANE_W-1:0]     last_lane,
   output logic                  last_tile
);

   localparam int unsigned PW = $clog2(PLANE + 1);
   localparam int unsigned CW = $clog2(NUM_CHANNEL + SYSTOLIC_SIZE + 1);

   localparam logic [PW-1:0]         PIX_STEP      = PW'(SYSTOLIC_SIZE);
   localparam logic [PW-1:0]         PIX_LAST      = PW'(PLANE - SYSTOLIC_SIZE);
   localparam logic [CW-1:0]         CH_STEP       = CW'(SYSTOLIC_SIZE);
   localparam logic [CW-1:0]         CH_LIMIT      = CW'(NUM_CHANNEL);
   localparam logic [ADDR_WIDTH-1:0] BASE_PIX_STEP = ADDR_WIDTH'(SYSTOLIC_SIZE);
   // Moving from the last pixel tile of group g to pixel 0 of group g+1:
   // (ch+S)*PLANE - (ch*PLANE + PLANE - S) = S + (S-1)*PLANE
   localparam logic [ADDR_WIDTH-1:0] BASE_GRP_STEP =
      ADDR_WIDTH'(SYSTOLIC_SIZE + (SYSTOLIC_SIZE - 1) * PLANE);

   logic [PW-1:0]         pix_base_r;
   logic [CW-1:0]         ch_base_r;
   logic [ADDR_WIDTH-1:0] tile_base_r;
   logic [PW-1:0]         pix_next_s;
   logic [CW-1:0]         ch_next_s;
   logic [CW-1:0]         remaining_s;

   // Derive next cursor values, active-lane count and the last-tile flag.
   always_comb begin
      pix_next_s  = pix_base_r + PIX_STEP;
      ch_next_s   = ch_base_r + CH_STEP;
      remaining_s = CH_LIMIT - ch_base_r;
      if (remaining_s >= CH_STEP) begin
         last_lane = LANE_W'(SYSTOLIC_SIZE - 1);
      end else begin
         // partial last channel group
         last_lane = LANE_W'(remaining_s - CW'(1));
      end
      last_tile = (pix_base_r == PIX_LAST) && (ch_next_s >= CH_LIMIT);
   end

   // Cursor registers with layer wrap-around.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_base_r  <= '0;
         ch_base_r   <= '0;
         tile_base_r <= '0;
      end else if (clear) begin
         pix_base_r  <= '0;
         ch_base_r   <= '0;
         tile_base_r <= '0;
      end else if (advance) begin
         if (pix_base_r == PIX_LAST) begin
            pix_base_r <= '0;
            if (ch_next_s >= CH_LIMIT) begin
               ch_base_r   <= '0;
               tile_base_r <= '0;
            end else begin
               ch_base_r   <= ch_next_s;
               tile_base_r <= tile_base_r + BASE_GRP_STEP;
            end
         end else begin
            pix_base_r  <= pix_next_s;
            tile_base_r <= tile_base_r + BASE_PIX_STEP;
         end
      end else begin
         pix_base_r  <= pix_base_r;
         ch_base_r   <= ch_base_r;
         tile_base_r <= tile_base_r;
      end
   end

   assign tile_base = tile_base_r;

endmodule

// File: rtl/ofm_addr_sequencer.sv
// ofm_addr_sequencer: channel-major OFM write-address generator for a
// systolic array (addr = ch*PLANE + pixel).
//   clk, rst_n : clock, asynchronous active-low reset
//   write      : tile ready to drain (ignored unless idle)
//   clear      : synchronous layer clear, highest priority
//   stall      : (only with OFM_ADDR_STALL_EN) pause emission in EMIT
//   ofm_addr   : current write address (holds while addr_valid=0)
//   addr_valid : ofm_addr/lane valid this cycle
//   lane       : PE lane whose data belongs at ofm_addr
//   busy       : sequencer not idle
//   done       : one-cycle pulse in the UPDATE cycle of the final tile
// Optional feature macro: OFM_ADDR_STALL_EN.
module ofm_addr_sequencer
   import ofm_addr_pkg::*;
#(
   parameter int unsigned SYSTOLIC_SIZE = 16,
   parameter int unsigned OFM_H         = 32,
   parameter int unsigned OFM_W         = 32,
   parameter int unsigned NUM_CHANNEL   = 16,
   parameter int unsigned ADDR_WIDTH    = 14
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 write,
   input  logic                                 clear,
`ifdef OFM_ADDR_STALL_EN
   input  logic                                 stall,
`endif
   output logic [ADDR_WIDTH-1:0]                ofm_addr,
   output logic                                 addr_valid,
   output logic [lane_width(SYSTOLIC_SIZE)-1:0] lane,
   output logic                                 busy,
   output logic                                 done
);

   localparam int unsigned PLANE  = calc_plane(OFM_H, OFM_W);
   localparam int unsigned LANE_W = lane_width(SYSTOLIC_SIZE);
   localparam logic [ADDR_WIDTH-1:0] PLANE_STEP = ADDR_WIDTH'(PLANE);

   state_t                state_r, state_next_s;
   logic [LANE_W-1:0]     lane_r, lane_next_s;
   logic [ADDR_WIDTH-1:0] ofm_addr_r, addr_next_s;
   logic                  valid_r, valid_next_s;
   logic                  busy_r;
   logic                  done_r, done_next_s;
   logic                  advance_s;
   logic                  stall_s;
   logic [ADDR_WIDTH-1:0] tile_base_s;
   logic [LANE_W-1:0]     last_lane_s;
   logic                  last_tile_s;

`ifdef OFM_ADDR_STALL_EN
   assign stall_s = stall;
`else
   assign stall_s = 1'b0;
`endif

   ofm_tile_cursor #(
      .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
      .PLANE         (PLANE),
      .NUM_CHANNEL   (NUM_CHANNEL),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .LANE_W        (LANE_W)
   ) u_cursor (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .advance   (advance_s),
      .tile_base (tile_base_s),
      .last_lane (last_lane_s),
      .last_tile (last_tile_s)
   );

   // FSM next state and next values of the registered outputs.
   always_comb begin
      state_next_s = state_r;
      lane_next_s  = lane_r;
      addr_next_s  = ofm_addr_r;
      valid_next_s = 1'b0;
      done_next_s  = 1'b0;
      advance_s    = 1'b0;
      if (clear) begin
         state_next_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (write) begin
                  state_next_s = ST_EMIT;
                  lane_next_s  = '0;
                  addr_next_s  = tile_base_s;
                  valid_next_s = 1'b1;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end
            ST_EMIT: begin
               if (valid_r && (lane_r == last_lane_s)) begin
                  state_next_s = ST_UPDATE;
                  done_next_s  = last_tile_s;
               end else begin
                  // A lane shown while valid is consumed; after a stall the
                  // held lane has not been shown yet and is presented as is.
                  if (valid_r) begin
                     lane_next_s = lane_r + LANE_W'(1);
                     addr_next_s = ofm_addr_r + PLANE_STEP;
                  end else begin
                     lane_next_s = lane_r;
                     addr_next_s = ofm_addr_r;
                  end
                  valid_next_s = !stall_s;
               end
            end
            ST_UPDATE: begin
               advance_s    = 1'b1;
               state_next_s = ST_IDLE;
            end
            default: begin
               state_next_s = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         lane_r     <= '0;
         ofm_addr_r <= '0;
         valid_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         lane_r     <= lane_next_s;
         ofm_addr_r <= addr_next_s;
         valid_r    <= valid_next_s;
         busy_r     <= (state_next_s != ST_IDLE);
         done_r     <= done_next_s;
      end
   end

   assign ofm_addr   = ofm_addr_r;
   assign addr_valid = valid_r;
   assign lane       = lane_r;
   assign busy       = busy_r;
   assign done       = done_r;

endmodule

// File: tb/tb_ofm_addr_sequencer.sv
// tb_ofm_addr_sequencer: directed bench for ofm_addr_sequencer with
// SYSTOLIC_SIZE=4, 4x4 map (PLANE=16), 6 channels, 7-bit addresses.
// Stall scenario is compiled in when OFM_ADDR_STALL_EN is defined.
module tb_ofm_addr_sequencer;

   logic       clk;
   logic       rst_n;
   logic       write;
   logic       clear;
   logic [6:0] ofm_addr;
   logic       addr_valid;
   logic [1:0] lane;
   logic       busy;
   logic       done;
`ifdef OFM_ADDR_STALL_EN
   logic       stall;
`endif

   int vectors = 0;
   int errors  = 0;

   ofm_addr_sequencer #(
      .SYSTOLIC_SIZE (4),
      .OFM_H         (4),
      .OFM_W         (4),
      .NUM_CHANNEL   (6),
      .ADDR_WIDTH    (7)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .write      (write),
      .clear      (clear),
`ifdef OFM_ADDR_STALL_EN
      .stall      (stall),
`endif
      .ofm_addr   (ofm_addr),
      .addr_valid (addr_valid),
      .lane       (lane),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag, input int last_addr);
      chk({tag, ".valid"}, 32'(addr_valid), 32'd0);
      chk({tag, ".busy"},  32'(busy),       32'd0);
      chk({tag, ".done"},  32'(done),       32'd0);
      chk({tag, ".addr"},  32'(ofm_addr),   32'(last_addr));
   endtask

   // One full tile: lanes 0..n-1 at base + k*16, one UPDATE cycle, then idle.
   task automatic burst(input string tag, input int base, input int n, input bit exp_done);
      write = 1'b1;
      step();
      write = 1'b0;
      for (int k = 0; k < n; k++) begin
         chk({tag, ".valid"}, 32'(addr_valid), 32'd1);
         chk({tag, ".lane"},  32'(lane),       32'(k));
         chk({tag, ".addr"},  32'(ofm_addr),   32'(base + 16 * k));
         chk({tag, ".busy"},  32'(busy),       32'd1);
         chk({tag, ".done"},  32'(done),       32'd0);
         step();
      end
      chk({tag, ".upd_valid"}, 32'(addr_valid), 32'd0);
      chk({tag, ".upd_busy"},  32'(busy),       32'd1);
      chk({tag, ".upd_done"},  32'(done),       32'(exp_done));
      step();
      chk_idle({tag, ".idle"}, base + 16 * (n - 1));
   endtask

   initial begin
      rst_n = 1'b0;
      write = 1'b0;
      clear = 1'b0;
`ifdef OFM_ADDR_STALL_EN
      stall = 1'b0;
`endif
      step();
      step();
      chk("rst.addr",  32'(ofm_addr),   32'd0);
      chk("rst.valid", 32'(addr_valid), 32'd0);
      chk("rst.lane",  32'(lane),       32'd0);
      chk("rst.busy",  32'(busy),       32'd0);
      chk("rst.done",  32'(done),       32'd0);
      rst_n = 1'b1;
      step();
      chk_idle("post_rst", 0);

      // Layer 1: four full-group tiles, then four partial-group tiles (n=2).
      burst("t1", 0,  4, 1'b0);
      burst("t2", 4,  4, 1'b0);
      burst("t3", 8,  4, 1'b0);
      burst("t4", 12, 4, 1'b0);
      burst("t5", 64, 2, 1'b0);
      burst("t6", 68, 2, 1'b0);
      burst("t7", 72, 2, 1'b0);
      burst("t8", 76, 2, 1'b1);
      // Cursor wrapped: next layer starts at 0 without a clear.
      burst("t9", 0,  4, 1'b0);

      // write re-pulsed during EMIT must be ignored (cursor now at pixel 4).
      write = 1'b1;
      step();
      write = 1'b0;
      chk("rewr.l0", 32'(ofm_addr), 32'd4);
      step();
      chk("rewr.l1", 32'(ofm_addr), 32'd20);
      write = 1'b1;
      step();
      write = 1'b0;
      chk("rewr.l2", 32'(ofm_addr), 32'd36);
      step();
      chk("rewr.l3", 32'(ofm_addr), 32'd52);
      step();
      chk("rewr.upd_valid", 32'(addr_valid), 32'd0);
      step();
      chk_idle("rewr.idle", 52);
      step();
      chk_idle("rewr.no_queue", 52);

      // clear during lane 2 of the tile at pixel 12.
      burst("t11", 8, 4, 1'b0);
      write = 1'b1;
      step();
      write = 1'b0;
      chk("clr.l0", 32'(ofm_addr), 32'd12);
      step();
      chk("clr.l1", 32'(ofm_addr), 32'd28);
      step();
      chk("clr.l2",       32'(ofm_addr),   32'd44);
      chk("clr.l2_valid", 32'(addr_valid), 32'd1);
      clear = 1'b1;
      write = 1'b1;
      step();
      clear = 1'b0;
      write = 1'b0;
      chk("clr.valid", 32'(addr_valid), 32'd0);
      chk("clr.busy",  32'(busy),       32'd0);
      step();
      chk("clr.stay_idle", 32'(busy), 32'd0);
      burst("clr.after", 0, 4, 1'b0);

      // Asynchronous reset mid-burst (cursor now at pixel 4).
      write = 1'b1;
      step();
      write = 1'b0;
      chk("arst.l0", 32'(ofm_addr), 32'd4);
      step();
      chk("arst.l1", 32'(ofm_addr), 32'd20);
      rst_n = 1'b0;
      #1;
      chk("arst.addr",  32'(ofm_addr),   32'd0);
      chk("arst.valid", 32'(addr_valid), 32'd0);
      chk("arst.lane",  32'(lane),       32'd0);
      chk("arst.busy",  32'(busy),       32'd0);
      chk("arst.done",  32'(done),       32'd0);
      step();
      rst_n = 1'b1;
      step();
      burst("arst.after", 0, 4, 1'b0);

`ifdef OFM_ADDR_STALL_EN
      // Stall three cycles where lane 1 would appear (cursor at pixel 4).
      write = 1'b1;
      step();
      write = 1'b0;
      chk("stl.l0_lane", 32'(lane),     32'd0);
      chk("stl.l0_addr", 32'(ofm_addr), 32'd4);
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("stl.hold_valid", 32'(addr_valid), 32'd0);
         chk("stl.hold_busy",  32'(busy),       32'd1);
      end
      stall = 1'b0;
      for (int k = 1; k < 4; k++) begin
         step();
         chk("stl.valid", 32'(addr_valid), 32'd1);
         chk("stl.lane",  32'(lane),       32'(k));
         chk("stl.addr",  32'(ofm_addr),   32'(4 + 16 * k));
      end
      step();
      chk("stl.upd_valid", 32'(addr_valid), 32'd0);
      chk("stl.upd_busy",  32'(busy),       32'd1);
      step();
      chk_idle("stl.idle", 52);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
